// File: rtl/alu_exec_unit.sv
// Registered ALU execution stage with an iterative shift-add multiplier.
// Optional build macro ALU_MUL_EARLY_EXIT_EN finishes MUL once the remaining multiplier is zero.
module alu_exec_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            alu_operation,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero,
   output logic                  done,
   output logic                  busy,
   output logic                  illegal_op
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_LUI = 4'b0010;
   localparam logic [3:0] OP_NOR = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_SUB = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;

   localparam logic [SHAMT_WIDTH-1:0] LAST_COUNT = SHAMT_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   result_reg, result_next;
   logic                    zero_reg, zero_next;
   logic                    illegal_reg, illegal_next;
   logic [DATA_WIDTH-1:0]   acc_reg, acc_next;
   logic [DATA_WIDTH-1:0]   mcand_reg, mcand_next;
   logic [DATA_WIDTH-1:0]   mplier_reg, mplier_next;
   logic [SHAMT_WIDTH-1:0]  count_reg, count_next;

   logic [DATA_WIDTH-1:0]   alu_value;
   logic                    alu_illegal;
   logic [DATA_WIDTH-1:0]   acc_sum;
   logic [DATA_WIDTH-1:0]   mplier_shifted;
   logic                    mul_finish;
   logic                    mul_skip;

   // Single-cycle datapath; illegal codes yield zero so the zero flag reads 1.
   always_comb begin
      alu_value   = '0;
      alu_illegal = 1'b0;
      case (alu_operation)
         OP_ADD:  alu_value = a + b;
         OP_AND:  alu_value = a & b;
         OP_LUI:  alu_value = b << 12;
         OP_NOR:  alu_value = ~(a | b);
         OP_OR:   alu_value = a | b;
         OP_SLL:  alu_value = a << b[SHAMT_WIDTH-1:0];
         OP_SRL:  alu_value = a >> b[SHAMT_WIDTH-1:0];
         OP_SUB:  alu_value = a - b;
         default: alu_illegal = (alu_operation != OP_MUL);
      endcase
   end

   assign acc_sum        = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
   assign mplier_shifted = mplier_reg >> 1;

`ifdef ALU_MUL_EARLY_EXIT_EN
   // Stop as soon as no multiplier bits remain; b=0 never enters MUL.
   assign mul_finish = (count_reg == LAST_COUNT) || (mplier_shifted == '0);
   assign mul_skip   = (b == '0);
`else
   assign mul_finish = (count_reg == LAST_COUNT);
   assign mul_skip   = 1'b0;
`endif

   always_comb begin
      state_next   = state_reg;
      result_next  = result_reg;
      zero_next    = zero_reg;
      illegal_next = illegal_reg;
      acc_next     = acc_reg;
      mcand_next   = mcand_reg;
      mplier_next  = mplier_reg;
      count_next   = count_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (alu_operation == OP_MUL) begin
                  mcand_next  = a;
                  mplier_next = b;
                  acc_next    = '0;
                  count_next  = '0;
                  if (mul_skip) begin
                     result_next  = '0;
                     zero_next    = 1'b1;
                     illegal_next = 1'b0;
                     state_next   = DONE;
                  end else begin
                     state_next = MUL;
                  end
               end else begin
                  result_next  = alu_value;
                  zero_next    = (alu_value == '0);
                  illegal_next = alu_illegal;
                  state_next   = DONE;
               end
            end
         end
         MUL: begin
            acc_next    = acc_sum;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_shifted;
            count_next  = count_reg + 1'b1;
            if (mul_finish) begin
               result_next  = acc_sum;
               zero_next    = (acc_sum == '0);
               illegal_next = 1'b0;
               state_next   = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         result_reg  <= '0;
         zero_reg    <= 1'b1;
         illegal_reg <= 1'b0;
         acc_reg     <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         result_reg  <= result_next;
         zero_reg    <= zero_next;
         illegal_reg <= illegal_next;
         acc_reg     <= acc_next;
         mcand_reg   <= mcand_next;
         mplier_reg  <= mplier_next;
         count_reg   <= count_next;
      end
   end

   assign result     = result_reg;
   assign zero       = zero_reg;
   assign illegal_op = illegal_reg;
   assign done       = (state_reg == DONE);
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal results plus
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_exec_unit;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3:0]    alu_operation;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic [DW-1:0] result;
   logic          zero;
   logic          done;
   logic          busy;
   logic          illegal_op;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   alu_exec_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .alu_operation(alu_operation),
      .a(a),
      .b(b),
      .result(result),
      .zero(zero),
      .done(done),
      .busy(busy),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic [DW-1:0] r;
      case (op)
         4'd0:    r = x + y;
         4'd1:    r = x & y;
         4'd2:    r = y << 12;
         4'd3:    r = ~(x | y);
         4'd4:    r = x | y;
         4'd5:    r = x << (y % 32);
         4'd6:    r = x >> (y % 32);
         4'd7:    r = x - y;
         4'd8:    r = x * y;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic int lat_of(input logic [3:0] op, input logic [DW-1:0] y);
      int h;
      if (op != 4'd8) return 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
      if (y == 0) return 1;
      h = 0;
      for (int i = 0; i < DW; i++) if (y[i]) h = i;
      return h + 2;
`else
      h = DW + 1;
      return h;
`endif
   endfunction

   int            m_cnt;
   logic [DW-1:0] m_res, m_pres;
   logic          m_zero, m_ill, m_pill;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt  <= 0;
         m_res  <= '0;
         m_zero <= 1'b1;
         m_ill  <= 1'b0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_cnt  <= lat_of(alu_operation, b);
            m_pres <= ref_result(alu_operation, a, b);
            m_pill <= (alu_operation > 4'd8);
            if (lat_of(alu_operation, b) == 1) begin
               m_res  <= ref_result(alu_operation, a, b);
               m_zero <= (ref_result(alu_operation, a, b) == 0);
               m_ill  <= (alu_operation > 4'd8);
            end
         end
      end else begin
         if (m_cnt == 2) begin
            m_res  <= m_pres;
            m_zero <= (m_pres == 0);
            m_ill  <= m_pill;
         end
         m_cnt <= m_cnt - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", 32'(busy), 32'(m_cnt != 0));
         check("done", 32'(done), 32'(m_cnt == 1));
         check("result", result, m_res);
         check("zero", 32'(zero), 32'(m_zero));
         check("illegal_op", 32'(illegal_op), 32'(m_ill));
      end
   end

   // ---------------- directed transactions ----------------
   task automatic run_op(input string name, input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [DW-1:0] exp_res, input logic exp_zero, input logic exp_ill,
                         input int exp_lat, input int repulse_at);
      int  n;
      bit  got;
      @(posedge clk); #1;
      start = 1'b1; alu_operation = op; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; alu_operation = 4'(op + 4'd1);
      n = 1; got = 1'b0;
      while (n <= 60 && !got) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
         end else begin
            @(posedge clk); #1;
            n++;
            if (n == repulse_at) begin
               start = 1'b1; alu_operation = 4'd8; a = 2; b = 2;
            end else if (n == repulse_at + 1) begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check({name, "_done_seen"}, 32'(got), 32'd1);
      check({name, "_latency"}, n, exp_lat);
      check({name, "_result"}, result, exp_res);
      check({name, "_zero"}, 32'(zero), 32'(exp_zero));
      check({name, "_illegal"}, 32'(illegal_op), 32'(exp_ill));
      $display("txn %s op=%b a=%h b=%h result=%h zero=%0d illegal=%0d latency=%0d", name, op, x, y, result, zero, illegal_op, n);
   endtask

   int mul_lat_big, mul_lat_small;
   bit seen_done;

   initial begin
      reset = 1'b1; start = 1'b0; alu_operation = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      @(negedge clk);
      check("reset_result", result, 32'h0);
      check("reset_zero", 32'(zero), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

`ifdef ALU_MUL_EARLY_EXIT_EN
      mul_lat_big   = 17;
      mul_lat_small = 3;
`else
      mul_lat_big   = 33;
      mul_lat_small = 33;
`endif

      run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b0, 1, 0);
      run_op("sub_wrap", 4'b0111, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 0);
      run_op("sll", 4'b0101, 32'd1, 32'h25, 32'h20, 1'b0, 1'b0, 1, 0);
      run_op("srl", 4'b0110, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 1, 0);
      run_op("lui", 4'b0010, 32'h0, 32'h12345, 32'h1234_5000, 1'b0, 1'b0, 1, 0);
      run_op("nor", 4'b0011, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F, 1'b0, 1'b0, 1, 0);
      run_op("and", 4'b0001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1, 0);
      run_op("mul_big", 4'b1000, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, mul_lat_big, 10);
      run_op("mul_small", 4'b1000, 32'd6, 32'd3, 32'd18, 1'b0, 1'b0, mul_lat_small, 0);
`ifdef ALU_MUL_EARLY_EXIT_EN
      run_op("mul_zero", 4'b1000, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1, 0);
`endif
      run_op("illegal", 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1, 0);
      run_op("or_after_ill", 4'b0100, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1, 0);

      // Reset in the middle of a multiply must abort it without a done pulse.
      @(posedge clk); #1;
      start = 1'b1; alu_operation = 4'b1000; a = 32'd7; b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      @(negedge clk);
      check("abort_result", result, 32'h0);
      check("abort_zero", 32'(zero), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      $display("txn abort_mul a=7 b=9 done_seen=%0d", seen_done);

      // Randomized traffic, including start while busy and occasional resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         reset = ($urandom_range(0, 399) == 0);
         start = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) < 13) alu_operation = 4'($urandom_range(0, 8));
         else alu_operation = 4'($urandom_range(9, 15));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(0, 40));
            1:       b = 32'h1 << $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if (start && !busy && !reset)
            $display("txn rand op=%b a=%h b=%h", alu_operation, a, b);
      end
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered execution stage directly downstream of the ALU control decoder in the RISC-V single-cycle core.
- Consumes the 4-bit ALU operation code plus two operands and produces a registered result, zero flag and completion handshake.
- Single-cycle ops finish with latency 1; MUL uses an iterative shift-add engine, so the core must stall on busy.

Parameters:
DATA_WIDTH, 32, operand/result width; MUL runs DATA_WIDTH iterations
SHAMT_WIDTH, 5, shift-amount bits taken from b; must equal log2(DATA_WIDTH)

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
alu_operation  input  4  op code from ALU control decoder
a  input  DATA_WIDTH  operand A (rs1)
b  input  DATA_WIDTH  operand B (rs2 or immediate)
result  output  DATA_WIDTH  registered result
zero  output  1  registered (result == 0)
done  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE
illegal_op  output  1  registered; set with done for undefined codes

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; result=0, zero=1, done=0, busy=0, illegal_op=0; internal counter, accumulator and multiplicand cleared.
- Reset mid-operation aborts any MUL. No done is issued for the aborted op.
- States:
  - IDLE: waits for start.
  - MUL: iterates.
  - DONE: asserts done for exactly one cycle, then returns to IDLE.
- Op codes:
  - 0000 add: a+b, wraps mod 2^DATA_WIDTH, carry discarded.
  - 0001 and.
  - 0010 lui: b<<12, truncated.
  - 0011 nor.
  - 0100 or.
  - 0101 sll: a << b[SHAMT_WIDTH-1:0].
  - 0110 srl: logical, a >> b[SHAMT_WIDTH-1:0].
  - 0111 sub: a-b, wraps.
  - 1000 mul: low DATA_WIDTH bits of a*b.
  - All other codes (including 1111) are illegal.
- IDLE with start=1 and a non-MUL code:
  - result, zero and illegal_op are registered at that edge; next state is DONE.
  - done=1 on the following cycle, i.e. latency 1.
  - Illegal code: result=0, zero=1, illegal_op=1.
- IDLE with start=1 and code 1000:
  - Latch multiplicand=a, multiplier=b; clear accumulator and counter; next state is MUL.
- MUL, each cycle:
  - If multiplier[0], accumulator += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - After the DATA_WIDTH-th iteration: result=accumulator, zero updated, next state DONE.
  - done is asserted DATA_WIDTH+1 cycles after the start edge (33 for default).
- Operand and code capture: a, b and alu_operation are captured at the start edge only; later input changes have no effect.
- start outside IDLE (busy=1): ignored, not queued. This includes start in the DONE cycle; the core must re-assert it.
- Output holding: result, zero and illegal_op hold until the next accepted op. illegal_op is cleared by the next legal op.
- busy: 1 in MUL and DONE, 0 in IDLE.
- done: 1 only in DONE.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- When defined: in MUL, if the remaining multiplier == 0 at the start of an iteration, result=accumulator and next state is DONE immediately, without performing that iteration.
  - Latency becomes (index of highest set bit of b)+2 cycles; b=0 gives 1 cycle.
- When undefined: fixed DATA_WIDTH-iteration MUL. The early-exit comparator is not synthesized.
- Non-MUL ops are identical in both builds.

Test Plan:
- Reset: reset=1 for 2 cycles mid-MUL (a=7, b=9) -> result=0, zero=1, busy=0, done never pulses for the aborted op.
- add/sub wrap:
  - op 0000, a=32'hFFFF_FFFF, b=1 -> next cycle done=1, result=0, zero=1.
  - op 0111, a=5, b=7 -> result=32'hFFFF_FFFE, zero=0.
- Shifts/lui:
  - op 0101, a=1, b=32'h0000_0025 (shamt 5) -> result=32'h20.
  - op 0110, a=32'h8000_0000, b=31 -> result=1.
  - op 0010, b=32'h12345 -> result=32'h1234_5000.
- MUL, fixed build: a=32'h0001_0001, b=32'h0000_FFFF, start pulsed once -> busy=1 for 33 cycles, done at cycle 33, result=32'hFFFF_FFFF. start re-pulsed at cycle 10 with a=2, b=2 is ignored.
- MUL, ALU_MUL_EARLY_EXIT_EN: a=6, b=3 -> done 3 cycles after start, result=18. b=0 -> done after 1 cycle, result=0, zero=1.
- Illegal: op 1111, a=3, b=4 -> done=1, illegal_op=1, result=0. Next op 0100, a=3, b=4 -> result=7, illegal_op=0.
